mme_tile_engine: RTL and testbench
==================================

Name: mme_tile_engine

Overview:
Parametrised N x N matrix-multiply compute core for the next-generation MME. It computes C = A(N x K) x B(K x N) by accumulating one outer product per accepted beat: one A column times one B row. It sits between the AXI read-side data mover, which feeds A columns and B rows, and the AXI write-side mover, which drains C row by row. Fixed 4 x 4 with 32-bit data generalises to N, DW and KMAX, with saturation and back-pressured drain.

Parameters:
N, 4, tile dimension (rows of A = columns of B = C is N x N); N >= 2.
DW, 32, element width, signed two's complement.
KMAX, 64, maximum inner dimension K; must be a power of 2.
KW, $clog2(KMAX)+1, width of mat_width.
ACC_W, 2*DW+$clog2(KMAX), accumulator width; guarantees no overflow for K <= KMAX.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  one-cycle command pulse; sampled only in IDLE.
mat_width  in  KW  inner dimension K; sampled with start.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse after the last C row is accepted.
in_valid  in  1  A/B beat valid.
in_ready  out  1  engine accepts a beat.
a_col  in  N*DW  A[0..N-1][k]; element i at bits [i*DW +: DW].
b_row  in  N*DW  B[k][0..N-1]; element j at bits [j*DW +: DW].
out_valid  out  1  C row valid.
out_ready  in  1  downstream accepts the C row.
c_row  out  N*DW  C[r][0..N-1]; element j at bits [j*DW +: DW].
c_row_idx  out  $clog2(N)  row index r.
out_last  out  1  high with row N-1.

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values: busy, done, in_ready, out_valid, out_last = 0; c_row, c_row_idx = 0; all accumulators 0; FSM in IDLE.
- Reset mid-operation: immediate return to the reset values. Any partial result is discarded. No done pulse.
- IDLE: in_ready = 0.
  - On start, latch K = min(mat_width, KMAX), clear all N*N accumulators and k_cnt.
  - K == 0 -> go to DRAIN, which outputs all-zero rows.
  - K > 0 -> go to ACC.
- ACC: in_ready = 1. Each beat with in_valid & in_ready:
  - acc[i][j] += sext(a_i * b_j) for every i, j.
  - The product is a full 2*DW-bit signed value, sign-extended to ACC_W.
  - The accumulator is updated on the same clock edge (single-cycle MAC).
  - k_cnt increments. The beat with k_cnt == K-1 moves the FSM to DRAIN on that edge.
  - in_valid low -> accumulators hold. Beats are never dropped.
- DRAIN: row counter r starts at 0. out_valid = 1, c_row = sat_or_trunc(acc[r][*]), c_row_idx = r, out_last = (r == N-1).
  - c_row, c_row_idx and out_last stay stable while out_valid & !out_ready.
  - On out_valid & out_ready: r increments. If r == N-1, go to DONE.
- DONE: done = 1 for exactly one cycle, out_valid = 0, then IDLE. Accumulators keep their contents until the next start.
- start outside IDLE is ignored, including start in the DONE cycle.
- in_valid outside ACC is ignored; in_ready stays 0 there.
- Output reduction (default): c_row element = acc[DW-1:0] (truncation, matching the 32-bit C word layout in memory).
- Latency:
  - start -> in_ready high: 1 cycle.
  - Last input beat -> first out_valid: 1 cycle.
  - Last out handshake -> done: 1 cycle.
  - Minimum command: 1 + K + N + 1 cycles.

Optional Feature:
MME_SAT_EN.
- Defined: each C element is saturated to signed DW range.
  - acc > 2^(DW-1)-1 -> 2^(DW-1)-1.
  - acc < -2^(DW-1) -> -2^(DW-1).
  - Otherwise acc[DW-1:0].
- Undefined: plain truncation to acc[DW-1:0]. Saturation logic is absent.

Decomposition:
- Package mme_pkg holds:
  - state enum {IDLE, ACC, DRAIN, DONE};
  - default localparams N_DEF, DW_DEF, KMAX_DEF;
  - function reduce_acc(), containing truncation or saturation under MME_SAT_EN.
- Sub-module mme_mac_cell: one accumulator with a clear, an enable and a signed multiply-add. Instantiated N*N times by generate.
- The FSM, counters and drain mux stay in the top module.

Test Plan:
- Reset, then start with K=4, A=B=identity (a_col = e_k, b_row = e_k) -> 4 rows out; C = identity with values 1/0; done pulses once; busy low afterwards.
- K=8, random 8-bit values as in the existing bench, in_valid toggled 50% -> C matches the golden model; beats are accepted only when in_valid & in_ready.
- K=0 start -> no in_ready; 4 zero rows with c_row_idx 0..3; out_last only on row 3; done.
- out_ready held low 5 cycles on row 1 -> c_row and c_row_idx stay stable; rows are not skipped.
- K=16, all A = 32'h7FFFFFFF and all B = 2:
  - MME_SAT_EN defined -> every C element = 32'h7FFFFFFF.
  - MME_SAT_EN undefined -> every C element = 32'hFFFFFFE0.
- Assert rst after 3 beats of a K=12 run, release, then start K=4 with known data -> no done for the aborted run; the second result is correct with no residue from the aborted run; start pulses while busy are ignored.

Source files
------------

// File: rtl/mme_pkg.sv
// Shared types and helpers for the MME tile engine.
// Build option: define MME_SAT_EN to saturate C elements to the signed DW
// range; without it C elements are plain truncations of the accumulator.
package mme_pkg;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_e;

    localparam int N_DEF    = 4;
    localparam int DW_DEF   = 32;
    localparam int KMAX_DEF = 64;

    // Widest accumulator / element the reduction helper handles.
    localparam int ACC_MAXW = 128;
    localparam int DW_MAXW  = 64;

    // Reduce a sign-extended accumulator to a dw-bit C element (low dw bits
    // of the result are meaningful; callers cast down to their DW).
    function automatic logic [DW_MAXW-1:0] reduce_acc(input logic signed [ACC_MAXW-1:0] acc,
                                                      input int unsigned dw);
        logic [DW_MAXW-1:0] mask;
`ifdef MME_SAT_EN
        logic signed [ACC_MAXW-1:0] hi;
        logic signed [ACC_MAXW-1:0] lo;
        hi = $signed((ACC_MAXW'(1) << (dw - 1)) - ACC_MAXW'(1));
        lo = ~hi;
`endif
        // Shifting by the full width yields 0, so mask becomes all ones.
        mask = (DW_MAXW'(1) << dw) - DW_MAXW'(1);
`ifdef MME_SAT_EN
        if (acc > hi)
            return hi[DW_MAXW-1:0] & mask;
        if (acc < lo)
            return lo[DW_MAXW-1:0] & mask;
`endif
        return acc[DW_MAXW-1:0] & mask;
    endfunction

endpackage

// File: rtl/mme_tile_engine_if.sv
// A/B beat input stream and C row output stream of the MME tile engine.
interface mme_tile_engine_if #(
    parameter int N  = 4,
    parameter int DW = 32
);
    localparam int RW = $clog2(N);

    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   a_col;
    logic [N*DW-1:0]   b_row;
    logic              out_valid;
    logic              out_ready;
    logic [N*DW-1:0]   c_row;
    logic [RW-1:0]     c_row_idx;
    logic              out_last;

    // Engine side.
    modport slave (
        input  in_valid, a_col, b_row, out_ready,
        output in_ready, out_valid, c_row, c_row_idx, out_last
    );

    // Data-mover side (feeds beats, drains rows).
    modport master (
        output in_valid, a_col, b_row, out_ready,
        input  in_ready, out_valid, c_row, c_row_idx, out_last
    );
endinterface

// File: rtl/mme_mac_cell.sv
// One C accumulator: synchronous clear, enabled signed multiply-accumulate.
module mme_mac_cell #(
    parameter int DW    = 32,
    parameter int ACC_W = 70
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [DW-1:0]    a,
    input  logic signed [DW-1:0]    b,
    output logic signed [ACC_W-1:0] acc
);
    logic signed [2*DW-1:0] prod;

    assign prod = a * b;

    // Clear on command start, otherwise add the full-width product per beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + ACC_W'(prod);
    end
endmodule

// File: rtl/mme_tile_engine.sv
// N x N outer-product matrix-multiply core: accumulates K beats of
// (A column x B row), then drains C one row per handshake.
// Build option: MME_SAT_EN selects saturating C output (see mme_pkg).
module mme_tile_engine
    import mme_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DW    = DW_DEF,
    parameter int KMAX  = KMAX_DEF,
    parameter int KW    = $clog2(KMAX) + 1,
    parameter int ACC_W = 2*DW + $clog2(KMAX)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [KW-1:0]  mat_width,
    output logic           busy,
    output logic           done,
    mme_tile_engine_if.slave bus
);
    localparam int RW = $clog2(N);

    state_e                          state, state_nx;
    logic [KW-1:0]                   k_req, k_len, k_cnt;
    logic [RW-1:0]                   r;
    logic                            clr, beat, last_beat, row_hs, last_row;
    logic                            in_ready, out_valid;
    logic [N-1:0][N-1:0][ACC_W-1:0]  acc;
    logic [N-1:0][ACC_W-1:0]         row_sel;
    logic [N*DW-1:0]                 row_red;

    assign k_req     = (mat_width > KW'(KMAX)) ? KW'(KMAX) : mat_width;
    assign clr       = (state == IDLE) && start;
    assign beat      = (state == ACC) && bus.in_valid;
    assign last_beat = beat && (k_cnt == k_len - KW'(1));
    assign row_hs    = (state == DRAIN) && bus.out_ready;
    assign last_row  = (r == RW'(N - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and handshake/status outputs.
    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = (k_req == '0) ? DRAIN : ACC;
            ACC: begin
                in_ready = 1'b1;
                if (last_beat) state_nx = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (row_hs && last_row) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latched K, beat counter and drain row counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_len <= '0;
            k_cnt <= '0;
            r     <= '0;
        end else begin
            if (clr) begin
                k_len <= k_req;
                k_cnt <= '0;
                r     <= '0;
            end else if (beat) begin
                k_cnt <= k_cnt + KW'(1);
            end
            if (row_hs)
                r <= last_row ? '0 : r + RW'(1);
        end
    end

    // N*N accumulators; cell (i,j) sees A element i and B element j.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            mme_mac_cell #(.DW(DW), .ACC_W(ACC_W)) u_mac (
                .clk (clk),
                .rst (rst),
                .clr (clr),
                .en  (beat),
                .a   (bus.a_col[i*DW +: DW]),
                .b   (bus.b_row[j*DW +: DW]),
                .acc (acc[i][j])
            );
        end
    end

    // Drain mux: pick row r, reduce each element to DW bits.
    assign row_sel = acc[r];
    for (genvar j = 0; j < N; j++) begin : g_red
        assign row_red[j*DW +: DW] = DW'(reduce_acc(ACC_MAXW'($signed(row_sel[j])), DW));
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.c_row     = out_valid ? row_red : '0;
    assign bus.c_row_idx = out_valid ? r : '0;
    assign bus.out_last  = out_valid && last_row;
endmodule

// File: tb/tb_mme_tile_engine.sv
// Randomised self-checking bench for mme_tile_engine with a sum-of-products
// reference model and a per-cycle output scoreboard.
module tb_mme_tile_engine;
    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int KMAX = 64;
    localparam int KW   = $clog2(KMAX) + 1;
    localparam int RW   = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] mat_width;
    logic          busy, done;

    mme_tile_engine_if #(.N(N), .DW(DW)) bus ();

    mme_tile_engine #(.N(N), .DW(DW), .KMAX(KMAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mat_width (mat_width),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, done_cnt = 0, rdy_hi = 0;

    typedef struct {
        logic [N*DW-1:0] row;
        logic [RW-1:0]   idx;
        logic            last;
    } row_t;
    row_t exp_q[$];

    logic signed [DW-1:0] am[KMAX][N];
    logic signed [DW-1:0] bm[KMAX][N];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [DW-1:0] model_red(input logic signed [127:0] s);
`ifdef MME_SAT_EN
        logic signed [127:0] hi, lo;
        hi = (128'sd1 <<< (DW - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        if (s > hi) return hi[DW-1:0];
        if (s < lo) return lo[DW-1:0];
`endif
        return s[DW-1:0];
    endfunction

    // C[r][j] = sum over accepted beats of A[r][k] * B[k][j]
    task automatic push_expected(input int k);
        for (int r = 0; r < N; r++) begin
            row_t e;
            for (int j = 0; j < N; j++) begin
                logic signed [127:0] s, x, y;
                s = 0;
                for (int kk = 0; kk < k; kk++) begin
                    x = am[kk][r];
                    y = bm[kk][j];
                    s = s + x * y;
                end
                e.row[j*DW +: DW] = model_red(s);
            end
            e.idx  = RW'(r);
            e.last = (r == N - 1);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: every cycle a row is offered it must match the head row.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (bus.in_ready) rdy_hi++;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL row_unexpected: got row idx %0d expected no row", bus.c_row_idx);
                end else begin
                    chk("c_row", bus.c_row, exp_q[0].row);
                    chk("c_row_idx", bus.c_row_idx, exp_q[0].idx);
                    chk("out_last", bus.out_last, exp_q[0].last);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cmd(input int mw);
        start     = 1'b1;
        mat_width = KW'(mw);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: identity, 1: random 8-bit, 2: 7FFFFFFF x 2, 3: random 32-bit
    task automatic feed(input int k, input int mode, input bit toggle, input bit spur);
        for (int b = 0; b < k; b++) begin
            bit acc_ok;
            int guard;
            guard = 0;
            while (toggle && $urandom_range(1) == 0 && guard < 8) begin
                bus.in_valid = 1'b0;
                bus.a_col = {$urandom, $urandom, $urandom, $urandom};
                bus.b_row = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk); #1;
                guard++;
            end
            for (int i = 0; i < N; i++) begin
                logic signed [7:0] t;
                case (mode)
                    0: begin am[b][i] = (i == b) ? 1 : 0; bm[b][i] = (i == b) ? 1 : 0; end
                    1: begin t = 8'($urandom); am[b][i] = t; t = 8'($urandom); bm[b][i] = t; end
                    2: begin am[b][i] = 32'h7FFFFFFF; bm[b][i] = 2; end
                    default: begin am[b][i] = $urandom; bm[b][i] = $urandom; end
                endcase
                bus.a_col[i*DW +: DW] = am[b][i];
                bus.b_row[i*DW +: DW] = bm[b][i];
            end
            bus.in_valid = 1'b1;
            if (spur && b == 0) begin start = 1'b1; mat_width = KW'(2); end
            acc_ok = 1'b0;
            guard  = 0;
            while (!acc_ok && guard < 50) begin
                @(negedge clk);
                acc_ok = bus.in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                guard++;
            end
            if (!acc_ok) begin
                n_chk++;
                $display("FAIL beat_timeout: got no in_ready for beat %0d expected acceptance", b);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int stall_row, input int stall_n, input bit rnd, input bit spur);
        for (int r = 0; r < N; r++) begin
            bit hs;
            int guard;
            bus.out_ready = 1'b0;
            if (r == stall_row) begin
                repeat (stall_n) begin @(posedge clk); #1; end
            end else if (rnd) begin
                repeat ($urandom_range(2)) begin @(posedge clk); #1; end
            end
            bus.out_ready = 1'b1;
            if (spur && r == 2) begin start = 1'b1; mat_width = KW'(5); end
            hs    = 1'b0;
            guard = 0;
            while (!hs && guard < 50) begin
                @(negedge clk);
                hs = bus.out_valid;
                @(posedge clk); #1;
                start = 1'b0;
                guard++;
            end
            if (!hs) begin
                n_chk++;
                $display("FAIL row_timeout: got no out_valid for row %0d expected a row", r);
            end
        end
        bus.out_ready = 1'b0;
        if (spur) begin start = 1'b1; mat_width = KW'(3); end
        @(negedge clk);
        chk("done_pulse", done, 1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("done_single", done, 0);
        chk("busy_after", busy, 0);
        chk("rows_left", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_quiet(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_c_row"}, bus.c_row, 0);
        chk({tag, "_c_row_idx"}, bus.c_row_idx, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; mat_width = '0;
        bus.in_valid = 1'b0; bus.a_col = '0; bus.b_row = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // identity, K=4
        cmd(4);
        @(negedge clk);
        chk("start_to_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        feed(4, 0, 1'b0, 1'b0);
        push_expected(4);
        chk("model_id_row0", exp_q[0].row, 1);
        chk("model_id_row3", exp_q[3].row, {32'd1, 96'd0});
        drain(-1, 0, 1'b0, 1'b0);
        chk("id_done_cnt", done_cnt, 1);

        // K=8 random 8-bit, in_valid toggled
        cmd(8);
        feed(8, 1, 1'b1, 1'b0);
        push_expected(8);
        @(negedge clk);
        chk("last_beat_to_valid", bus.out_valid, 1);
        @(posedge clk); #1;
        drain(-1, 0, 1'b1, 1'b0);

        // K=0: no beats, zero rows
        rdy_hi = 0;
        cmd(0);
        for (int k = 0; k < KMAX; k++)
            for (int i = 0; i < N; i++) begin am[k][i] = 0; bm[k][i] = 0; end
        push_expected(0);
        chk("model_k0_row", exp_q[2].row, 0);
        drain(-1, 0, 1'b0, 1'b0);
        chk("k0_no_ready", rdy_hi, 0);

        // row 1 stalled for 5 cycles
        cmd(4);
        feed(4, 1, 1'b0, 1'b0);
        push_expected(4);
        drain(1, 5, 1'b0, 1'b0);

        // K=16 overflow of the DW range
        cmd(16);
        feed(16, 2, 1'b1, 1'b0);
        push_expected(16);
`ifdef MME_SAT_EN
        chk("model_sat", exp_q[1].row, {4{32'h7FFFFFFF}});
`else
        chk("model_trunc", exp_q[1].row, {4{32'hFFFFFFE0}});
`endif
        drain(-1, 0, 1'b1, 1'b0);

        // mat_width above KMAX clamps to KMAX
        cmd(127);
        feed(KMAX, 3, 1'b0, 1'b0);
        push_expected(KMAX);
        drain(-1, 0, 1'b1, 1'b0);

        // abort a K=12 run after 3 beats, then a clean K=4 run
        dc = done_cnt;
        cmd(12);
        feed(3, 3, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_quiet("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_no_done", done_cnt, dc);
        cmd(4);
        feed(4, 1, 1'b1, 1'b1);
        push_expected(4);
        drain(-1, 0, 1'b1, 1'b1);
        chk("abort_done_cnt", done_cnt, dc + 1);
        chk("total_done_cnt", done_cnt, 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
